// File: rtl/pwm_array.sv
// Multi-channel PWM generator: serial duty load into a shadow bank, swapped into the active bank at period boundaries.
// Define PWM_ARRAY_CENTER_ALIGN_EN for centre-aligned outputs; edge-aligned otherwise.
module pwm_array #(
    parameter int CHANNELS = 8,
    parameter int DWIDTH   = 8,
    parameter int PRESC_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                data_valid,
    input  logic [DWIDTH-1:0]   data,
    output logic                ready,
    input  logic                mode,
    input  logic [PRESC_W-1:0]  prescale,
    output logic [0:CHANNELS-1] out,
    output logic                hsync,
    output logic                frame_done,
    output logic                busy
);

    localparam int                IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(CHANNELS - 1);
    localparam logic [DWIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_next;
    logic [DWIDTH-1:0]   cnt, cnt_next;
    logic [PRESC_W-1:0]  presc, presc_next;
    logic [DWIDTH-1:0]   shadow      [CHANNELS];
    logic [DWIDTH-1:0]   active      [CHANNELS];
    logic [DWIDTH-1:0]   active_next [CHANNELS];
    logic [IDX_W-1:0]    index, wr_idx;
    logic                pending, swap, hsync_next, tick, wr_en;
    logic [0:CHANNELS-1] out_next;

    // Level of one channel for a given counter value and duty.
    function automatic logic level(input logic [DWIDTH-1:0] c, input logic [DWIDTH-1:0] duty);
`ifdef PWM_ARRAY_CENTER_ALIGN_EN
        logic [DWIDTH:0] off;
        off = ({1'b1, {DWIDTH{1'b0}}} - {1'b0, duty}) >> 1;
        return ({1'b0, c} >= off) && ({1'b0, c} < off + {1'b0, duty});
`else
        return c < duty;
`endif
    endfunction

    assign ready  = !pending;
    assign busy   = (state == RUN);
    assign wr_en  = data_valid && !pending && (start || index != '0);
    assign wr_idx = start ? '0 : index;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_next = state;
        cnt_next   = cnt;
        presc_next = presc;
        swap       = 1'b0;
        hsync_next = 1'b0;
        frame_done = 1'b0;
        tick       = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    swap       = 1'b1;
                    state_next = RUN;
                    cnt_next   = '0;
                    presc_next = '0;
                    hsync_next = 1'b1;
                end
            end
            RUN: begin
                // >= so a lowered prescale cannot strand the divider above its new limit.
                tick = (presc >= prescale);
                if (tick) begin
                    presc_next = '0;
                    if (cnt == CNT_MAX) begin
                        frame_done = 1'b1;
                        cnt_next   = '0;
                        if (mode) begin
                            hsync_next = 1'b1;
                            swap       = pending;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    presc_next = presc + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are registered from next-cycle values so out lines up with cnt and hsync.
        for (int i = 0; i < CHANNELS; i++) begin
            active_next[i] = swap ? shadow[i] : active[i];
            out_next[i]    = (state_next == RUN) && level(cnt_next, active_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            presc <= '0;
            hsync <= 1'b0;
            out   <= '0;
            // NOTE: the duty banks are small register files, and a defined post-reset duty is required, so they are reset too.
            for (int i = 0; i < CHANNELS; i++) active[i] <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            presc <= presc_next;
            hsync <= hsync_next;
            out   <= out_next;
            for (int i = 0; i < CHANNELS; i++) active[i] <= active_next[i];
        end
    end

    // Shadow bank fill; swap and word acceptance are mutually exclusive through pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            index   <= '0;
            for (int i = 0; i < CHANNELS; i++) shadow[i] <= '0;
        end else begin
            if (swap) pending <= 1'b0;
            if (wr_en) begin
                shadow[wr_idx] <= data;
                if (wr_idx == LAST) begin
                    pending <= 1'b1;
                    index   <= '0;
                end else begin
                    index <= wr_idx + 1'b1;
                end
            end
        end
    end

endmodule
